// File: rtl/baseline_sub.sv
// Baseline subtraction for a 32-entry RAM sweep: the first NBASE samples set the
// baseline (truncated mean), the remaining samples are emitted as sample - baseline.
module baseline_sub #(
  parameter int DW    = 12,
  parameter int NBASE = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rd_en,
  input  logic [4:0]    addr,
  input  logic [DW-1:0] ram_q,
  output logic [DW:0]   dout,
  output logic          dout_valid,
  output logic [4:0]    dout_idx,
  output logic          busy,
  output logic          done,
  output logic          abort
);

  localparam int SH = $clog2(NBASE);
  localparam int AW = DW + SH;
  localparam logic [4:0] BASE_LAST = 5'(NBASE - 1);
  localparam logic [4:0] LAST_IDX  = 5'd31;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCUM   = 2'd1,
    CORRECT = 2'd2
  } state_t;

  state_t        state;
  logic          d_en;
  logic          d_en_q;
  logic [4:0]    d_addr;
  logic [4:0]    d_addr_q;
  logic [AW-1:0] acc;
  logic [DW-1:0] baseline;

  logic [4:0]    next_addr;
  logic          seq_ok;
  logic          start;
  logic [AW-1:0] acc_sum;
  logic [DW:0]   diff;

  // A sweep continues only while d_en stays high and addresses step by exactly one.
  assign next_addr = d_addr_q + 5'd1;
  assign seq_ok    = d_en && (d_addr == next_addr);
  assign start     = d_en && !d_en_q && (d_addr == 5'd0);
  assign acc_sum   = acc + {{SH{1'b0}}, ram_q};
  assign diff      = {1'b0, ram_q} - {1'b0, baseline};
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      d_en       <= 1'b0;
      d_en_q     <= 1'b0;
      d_addr     <= '0;
      d_addr_q   <= '0;
      acc        <= '0;
      baseline   <= '0;
      dout       <= '0;
      dout_idx   <= '0;
      dout_valid <= 1'b0;
      done       <= 1'b0;
      abort      <= 1'b0;
    end else begin
      d_en       <= rd_en;
      d_addr     <= addr;
      d_en_q     <= d_en;
      d_addr_q   <= d_addr;
      dout_valid <= 1'b0;
      done       <= 1'b0;
      abort      <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            acc   <= {{SH{1'b0}}, ram_q};
            state <= ACCUM;
          end
        end
        ACCUM: begin
          if (!seq_ok) begin
            abort <= 1'b1;
            acc   <= '0;
            state <= IDLE;
          end else begin
            acc <= acc_sum;
            if (d_addr == BASE_LAST) begin
              baseline <= acc_sum[AW-1:SH];
              state    <= CORRECT;
            end
          end
        end
        CORRECT: begin
          if (!seq_ok) begin
            abort <= 1'b1;
            acc   <= '0;
            state <= IDLE;
          end else begin
            dout       <= diff;
            dout_idx   <= d_addr;
            dout_valid <= 1'b1;
            // Returning to IDLE with d_en still high blocks a wrap-around restart.
            if (d_addr == LAST_IDX) begin
              done  <= 1'b1;
              acc   <= '0;
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_baseline_sub.sv
// Bench for baseline_sub: directed sweeps plus random sweeps against a sweep-level model.
module tb_baseline_sub;

  logic        clk;
  logic        rst;
  logic        rd_en;
  logic [4:0]  addr;
  logic [11:0] ram_q;
  logic [12:0] dout;
  logic        dout_valid;
  logic [4:0]  dout_idx;
  logic        busy;
  logic        done;
  logic        abort;

  baseline_sub #(.DW(12), .NBASE(8)) dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .addr(addr), .ram_q(ram_q),
    .dout(dout), .dout_valid(dout_valid), .dout_idx(dout_idx),
    .busy(busy), .done(done), .abort(abort)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // synchronous RAM model: data one cycle after the address
  logic [11:0] ram [32];
  always @(posedge clk) ram_q <= ram[addr];

  int n_cmp;
  int n_err;
  int seq [64];
  logic [17:0] exp_q [$];
  int done_cnt;
  int abort_cnt;
  bit busy_seen;
  logic [12:0] last_dout;
  logic [4:0]  last_idx;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // scoreboard / monitor
  always @(negedge clk) begin
    logic [17:0] e;
    if (rst) begin
      last_dout = '0;
      last_idx  = '0;
    end else begin
      if (busy) busy_seen = 1'b1;
      if (done) done_cnt++;
      if (abort) abort_cnt++;
      if (done || abort) check("done_abort_excl", {31'b0, done & abort}, 32'd0);
      if (dout_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_valid_idx", {27'b0, dout_idx}, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("dout_idx", {27'b0, dout_idx}, {27'b0, e[17:13]});
          check("dout", {19'b0, dout}, {19'b0, e[12:0]});
          check("done_at_31", {31'b0, done}, {31'b0, e[17:13] == 5'd31});
        end
        last_dout = dout;
        last_idx  = dout_idx;
      end else begin
        check("dout_hold", {19'b0, dout}, {19'b0, last_dout});
        check("idx_hold", {27'b0, dout_idx}, {27'b0, last_idx});
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_dout"}, {19'b0, dout}, 32'd0);
    check({tag, "_idx"}, {27'b0, dout_idx}, 32'd0);
    check({tag, "_valid"}, {31'b0, dout_valid}, 32'd0);
    check({tag, "_busy"}, {31'b0, busy}, 32'd0);
    check({tag, "_done"}, {31'b0, done}, 32'd0);
    check({tag, "_abort"}, {31'b0, abort}, 32'd0);
  endtask

  // Drives seq[0..len-1] with rd_en high; with_rst pulses reset in place of the next address.
  task automatic run_sweep(input int len, input bit with_rst);
    int base;
    int lim;
    int i;
    bit exp_done;
    bit exp_abort;
    logic [12:0] d;
    base = 0;
    for (int k = 0; k < 8; k++) base += int'(ram[k]);
    base = base / 8;
    lim = with_rst ? len - 1 : len;
    i = 0;
    if (seq[0] == 0)
      while (i < lim && i < 32 && seq[i] == i) begin
        if (i >= 8) begin
          d = 13'(ram[i]) - 13'(base);
          exp_q.push_back({5'(i), d});
        end
        i++;
      end
    exp_done  = !with_rst && seq[0] == 0 && i == 32;
    exp_abort = !with_rst && seq[0] == 0 && i < 32;
    done_cnt = 0;
    abort_cnt = 0;
    busy_seen = 1'b0;
    for (int k = 0; k < len; k++) begin
      @(posedge clk); #1;
      rd_en = 1'b1;
      addr  = 5'(seq[k]);
    end
    if (with_rst) begin
      @(posedge clk);
      @(negedge clk); #1;
      rst   = 1'b1;
      rd_en = 1'b0;
      #1 check_all_zero("rst_mid");
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
    end else begin
      @(posedge clk); #1;
      rd_en = 1'b0;
      addr  = 5'($urandom_range(0, 31));
    end
    repeat (6) @(posedge clk);
    @(negedge clk); #1;
    check("leftover_outputs", exp_q.size(), 32'd0);
    check("done_count", done_cnt, {31'b0, exp_done});
    check("abort_count", abort_cnt, {31'b0, exp_abort});
    check("busy_seen", {31'b0, busy_seen}, {31'b0, seq[0] == 0});
    check("busy_after", {31'b0, busy}, 32'd0);
    exp_q.delete();
  endtask

  task automatic fill_seq(input int first, input int len);
    for (int k = 0; k < len; k++) seq[k] = (first + k) % 32;
  endtask

  task automatic fill_ram_rand();
    for (int k = 0; k < 32; k++) ram[k] = 12'($urandom_range(0, 4095));
  endtask

  initial begin
    int kind;
    int len;
    int pos;
    int off;
    n_cmp = 0;
    n_err = 0;
    rst   = 1'b1;
    rd_en = 1'b0;
    addr  = '0;
    for (int k = 0; k < 32; k++) ram[k] = '0;
    #3 check_all_zero("reset");
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);

    // baseline 100, samples 150 -> +50
    for (int k = 0; k < 32; k++) ram[k] = (k < 8) ? 12'd100 : 12'd150;
    fill_seq(0, 32);
    run_sweep(32, 1'b0);

    // full-scale baseline, zero sample -> -4095
    fill_ram_rand();
    for (int k = 0; k < 8; k++) ram[k] = 12'd4095;
    ram[8] = 12'd0;
    run_sweep(32, 1'b0);

    // truncated baseline: sum 9 -> 1
    fill_ram_rand();
    for (int k = 0; k < 7; k++) ram[k] = 12'd1;
    ram[7] = 12'd2;
    ram[8] = 12'd1;
    run_sweep(32, 1'b0);

    // rd_en dropped after address 15
    fill_ram_rand();
    run_sweep(16, 1'b0);

    // rise at address 5 is ignored, then a proper sweep
    fill_seq(5, 27);
    run_sweep(27, 1'b0);
    fill_seq(0, 32);
    run_sweep(32, 1'b0);

    // reset while the output for index 20 is on dout
    fill_ram_rand();
    run_sweep(22, 1'b1);
    fill_ram_rand();
    run_sweep(32, 1'b0);

    // wrap past 31 with rd_en still high: no restart
    fill_seq(0, 36);
    run_sweep(36, 1'b0);

    for (int n = 0; n < 25; n++) begin
      fill_ram_rand();
      kind = $urandom_range(0, 4);
      case (kind)
        0: begin len = 32; fill_seq(0, len); end
        1: begin len = $urandom_range(1, 31); fill_seq(0, len); end
        2: begin
          len = 32;
          pos = $urandom_range(1, 30);
          off = $urandom_range(2, 5);
          for (int k = 0; k < len; k++) seq[k] = (k < pos) ? k : (k + off) % 32;
        end
        3: begin pos = $urandom_range(1, 31); len = 32 - pos; fill_seq(pos, len); end
        default: begin len = $urandom_range(33, 40); fill_seq(0, len); end
      endcase
      run_sweep(len, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/baseline_sub.md
BASELINE_SUB -- requirements
Module: baseline_sub

Interface
REQ-001 SHALL have parameter DW, default 12, meaning RAM sample width in bits (unsigned samples).
REQ-002 SHALL have parameter NBASE, default 8, meaning number of leading samples averaged for the baseline; fixed power of two, 8 only.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-005 SHALL have port rd_en, input, 1 bit: high while the readout stage sweeps RAM addresses.
REQ-006 SHALL have port addr, input, 5 bits: address currently presented to the 32-entry RAM.
REQ-007 SHALL have port ram_q, input, DW bits: RAM read data, valid one cycle after addr.
REQ-008 SHALL have port dout, output, DW+1 bits: signed two's-complement corrected sample.
REQ-009 SHALL have port dout_valid, output, 1 bit: dout and dout_idx valid this cycle.
REQ-010 SHALL have port dout_idx, output, 5 bits: RAM address of the sample on dout.
REQ-011 SHALL have port busy, output, 1 bit: high in states ACCUM and CORRECT.
REQ-012 SHALL have port done, output, 1 bit: one-cycle pulse on completion of a full sweep.
REQ-013 SHALL have port abort, output, 1 bit: one-cycle pulse when a sweep is abandoned.

Function
REQ-014 SHALL register rd_en and addr once (d_en, d_addr) so that d_addr aligns with ram_q.
REQ-015 SHALL implement states IDLE, ACCUM and CORRECT.
REQ-016 IDLE -> ACCUM SHALL occur only when d_en is 1, d_addr is 0, and d_en was 0 in the previous cycle; sample 0 SHALL be accumulated in that same cycle.
REQ-017 A d_en rise with d_addr not equal to 0 SHALL be ignored; the block SHALL stay in IDLE until d_en falls and rises again.
REQ-018 ACCUM SHALL add ram_q into an unsigned accumulator of DW+3 bits for d_addr 0..7; the accumulator SHALL not overflow (8 x 4095 = 32760).
REQ-019 On d_addr 7, baseline SHALL be registered as (acc + ram_q) >> 3, truncated (not rounded), and the state SHALL move to CORRECT.
REQ-020 In CORRECT, for each d_addr 8..31, the block SHALL register dout = ram_q - baseline (signed, DW+1 bits), dout_idx = d_addr and dout_valid = 1 on the next clock edge.
REQ-021 Latency SHALL be 2 cycles: addr presented at cycle t, and dout_valid and dout at cycle t+2.
REQ-022 dout_valid SHALL never assert for indices 0..7; exactly 24 valid outputs SHALL occur per complete sweep.
REQ-023 done SHALL pulse in the same cycle as dout_valid for dout_idx 31; the state SHALL then return to IDLE.
REQ-024 In ACCUM or CORRECT, if d_en is 0 or d_addr is not equal to the previous d_addr + 1, the block SHALL pulse abort for one cycle, go to IDLE, clear the accumulator, and emit no further dout_valid.
REQ-025 A sweep in which d_en stays high after d_addr 31 with d_addr wrapping to 0 SHALL not restart; a restart SHALL require a d_en rise.
REQ-026 done and abort SHALL be mutually exclusive.
REQ-027 dout and dout_idx SHALL hold their last value when dout_valid is 0.

Reset
REQ-028 rst high SHALL asynchronously force: state IDLE, d_en 0, d_addr 0, accumulator 0, baseline 0, dout 0, dout_idx 0, dout_valid 0, busy 0, done 0, abort 0.
REQ-029 rst asserted mid-sweep SHALL abandon the sweep without an abort pulse.
REQ-030 After rst is released, a sweep SHALL start only on a fresh d_en rise with d_addr 0.

Verification
REQ-031 Full sweep with RAM[0..7] = 100 and RAM[8..31] = 150 -> 24 outputs, each dout = +50, idx 8..31 consecutive, done with idx 31.
REQ-032 RAM[0..7] = 4095 and RAM[8] = 0 -> baseline 4095, and dout for idx 8 = -4095 (13'h1001).
REQ-033 RAM[0..7] = {1,1,1,1,1,1,1,2} -> baseline 1 (truncation), and a sample of 1 yields dout = 0.
REQ-034 rd_en dropped after addr 15 -> abort pulse one cycle, no done, and the last dout_valid is for idx 14 or 15 according to the pipeline position.
REQ-035 rd_en rises with addr 5 -> no busy and no outputs; a later proper sweep from addr 0 completes normally.
REQ-036 rst pulsed at idx 20 -> all outputs 0 immediately with no abort pulse; the next sweep produces correct results.
